// File: rtl/altera_up_audio_in_deserializer.sv
// I2S (or left-justified, with AUDIO_IN_LEFT_JUSTIFIED_EN) serial audio input deserializer.
// It captures stereo pairs from edge pulses in the clk domain and buffers them in a show-ahead FIFO.
module altera_up_audio_in_deserializer #(
  parameter int AUDIO_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           bit_clk_rising_edge,
  input  logic                           left_right_clk_rising_edge,
  input  logic                           left_right_clk_falling_edge,
  input  logic                           serial_audio_in_data,
  input  logic                           read_en,
  output logic [AUDIO_DATA_WIDTH-1:0]    left_channel_data,
  output logic [AUDIO_DATA_WIDTH-1:0]    right_channel_data,
  output logic                           data_valid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(AUDIO_DATA_WIDTH + 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  logic left_start;
  logic right_start;
  logic delay_en;

`ifdef AUDIO_IN_LEFT_JUSTIFIED_EN
  assign left_start  = left_right_clk_rising_edge;
  assign right_start = left_right_clk_falling_edge;
  assign delay_en    = 1'b0;
`else
  assign left_start  = left_right_clk_falling_edge;
  assign right_start = left_right_clk_rising_edge;
  assign delay_en    = 1'b1;
`endif

  state_t state;
  state_t state_next;
  logic   push_req;
  logic   capture_left;
  logic   entering;

  always_comb begin
    state_next   = state;
    push_req     = 1'b0;
    capture_left = 1'b0;
    if (clear || (left_start && right_start)) begin
      state_next = SYNC;
    end else begin
      case (state)
        SYNC:  if (left_start) state_next = LEFT;
        LEFT:  if (right_start) begin
                 state_next   = RIGHT;
                 capture_left = 1'b1;
               end
        RIGHT: if (left_start) begin
                 state_next = LEFT;
                 push_req   = 1'b1;
               end
        default: state_next = SYNC;
      endcase
    end
  end

  assign entering = (state_next != state) && (state_next != SYNC);

  logic [AUDIO_DATA_WIDTH-1:0] shift_reg;
  logic [AUDIO_DATA_WIDTH-1:0] shift_insert;
  logic [AUDIO_DATA_WIDTH-1:0] left_hold;
  logic [BCW-1:0]              bit_count;
  logic                        delay_pending;

  // The bit selected by the counter takes the new serial bit (MSB first); the others keep their value.
  for (genvar gi = 0; gi < AUDIO_DATA_WIDTH; gi++) begin : g_insert
    assign shift_insert[gi] = (bit_count == BCW'(AUDIO_DATA_WIDTH - 1 - gi)) ?
                              serial_audio_in_data : shift_reg[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SYNC;
      shift_reg     <= '0;
      left_hold     <= '0;
      bit_count     <= '0;
      delay_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (capture_left) left_hold <= shift_reg;
      if (entering) begin
        shift_reg     <= '0;
        bit_count     <= '0;
        // A bit pulse coincident with the channel edge consumes the delay slot.
        delay_pending <= delay_en && !bit_clk_rising_edge;
      end else if (state != SYNC && bit_clk_rising_edge) begin
        if (delay_pending) begin
          delay_pending <= 1'b0;
        end else if (bit_count < BCW'(AUDIO_DATA_WIDTH)) begin
          shift_reg <= shift_insert;
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

  logic [AUDIO_DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
  logic [AUDIO_DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        overflow_reg;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        do_pop;
  logic                        do_push;
  logic                        drop;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign do_pop     = read_en && !fifo_empty && !clear;
  // A full FIFO still accepts the pair when a pop frees a slot in the same cycle.
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign drop       = push_req && fifo_full && !do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_left[wr_ptr]  <= left_hold;
      mem_right[wr_ptr] <= shift_reg;
    end
  end

  assign data_valid         = !fifo_empty;
  assign fifo_count         = count;
  assign overflow           = overflow_reg;
  assign left_channel_data  = fifo_empty ? '0 : mem_left[rd_ptr];
  assign right_channel_data = fifo_empty ? '0 : mem_right[rd_ptr];

endmodule

// File: tb/tb_altera_up_audio_in_deserializer.sv
// Scoreboard bench for altera_up_audio_in_deserializer: directed frames, expected pairs queued,
// a negedge monitor compares every pop against the queue head.
module tb_altera_up_audio_in_deserializer;

  localparam int W = 16;
  localparam int D = 4;
`ifdef AUDIO_IN_LEFT_JUSTIFIED_EN
  localparam int DLY          = 0;
  localparam bit LEFT_IS_RISE = 1'b1;
`else
  localparam int DLY          = 1;
  localparam bit LEFT_IS_RISE = 1'b0;
`endif
  localparam int PAD = 32 - DLY - 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         bclk;
  logic         lr_rise;
  logic         lr_fall;
  logic         sdata;
  logic         read_en;
  logic [W-1:0] left_channel_data;
  logic [W-1:0] right_channel_data;
  logic         data_valid;
  logic [2:0]   fifo_count;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  altera_up_audio_in_deserializer #(.AUDIO_DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .clear                       (clear),
    .bit_clk_rising_edge         (bclk),
    .left_right_clk_rising_edge  (lr_rise),
    .left_right_clk_falling_edge (lr_fall),
    .serial_audio_in_data        (sdata),
    .read_en                     (read_en),
    .left_channel_data           (left_channel_data),
    .right_channel_data          (right_channel_data),
    .data_valid                  (data_valid),
    .fifo_count                  (fifo_count),
    .overflow                    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lr_edge(input bit left);
    if (left == LEFT_IS_RISE) lr_rise = 1'b1;
    else                      lr_fall = 1'b1;
    step();
    lr_rise = 1'b0;
    lr_fall = 1'b0;
  endtask

  task automatic bit_pulse(input logic v);
    sdata = v;
    bclk  = 1'b1;
    step();
    bclk  = 1'b0;
    step();
  endtask

  // Channel edge, optional discarded delay bit (set to 1), ndata bits MSB first, then npad junk ones.
  task automatic send_slot(input bit left, input logic [31:0] word, input int ndata, input int npad);
    lr_edge(left);
    for (int k = 0; k < DLY; k++) bit_pulse(1'b1);
    for (int k = 0; k < ndata; k++) bit_pulse(word[ndata-1-k]);
    for (int k = 0; k < npad; k++) bit_pulse(1'b1);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b1, {16'h0, l}, 16, PAD);
    send_slot(1'b0, {16'h0, r}, 16, PAD);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic pop_n(input int n);
    read_en = 1'b1;
    repeat (n) step();
    read_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && read_en && data_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got %h_%h expected no pair", left_channel_data, right_channel_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_left",  {16'h0, left_channel_data},  {16'h0, mon_exp[31:16]});
        chk("pop_right", {16'h0, right_channel_data}, {16'h0, mon_exp[15:0]});
      end
    end
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; bclk = 1'b0; lr_rise = 1'b0; lr_fall = 1'b0;
    sdata = 1'b0; read_en = 1'b0;
    repeat (3) step();
    chk("reset_valid", {31'h0, data_valid}, 32'h0);
    chk("reset_count", {29'h0, fifo_count}, 32'h0);
    chk("reset_overflow", {31'h0, overflow}, 32'h0);
    chk("reset_left", {16'h0, left_channel_data}, 32'h0);
    chk("reset_right", {16'h0, right_channel_data}, 32'h0);
    reset_n = 1'b1;
    step();

    // Basic frame: pair appears one cycle after the closing left-start edge.
    send_frame(16'hA5C3, 16'h1234);
    chk("t1_valid_before_edge", {31'h0, data_valid}, 32'h0);
    exp_q.push_back({16'hA5C3, 16'h1234});
    lr_edge(1'b1);
    chk("t1_valid_after_edge", {31'h0, data_valid}, 32'h1);
    chk("t1_count", {29'h0, fifo_count}, 32'h1);
    pop_n(1);
    chk("t1_count_after_pop", {29'h0, fifo_count}, 32'h0);
    chk("t1_left_empty_zero", {16'h0, left_channel_data}, 32'h0);

    // Mid-frame reset, then a right slot before sync must not appear.
    send_slot(1'b1, 32'h0000_7777, 8, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("t2_count_after_reset", {29'h0, fifo_count}, 32'h0);
    send_slot(1'b0, 32'h0000_DEAD, 16, PAD);
    send_frame(16'h1111, 16'h2222);
    exp_q.push_back({16'h1111, 16'h2222});
    lr_edge(1'b1);
    chk("t2_count", {29'h0, fifo_count}, 32'h1);
    pop_n(1);

    // Six frames, no reads: four kept, overflow set, oldest at head.
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      send_frame(16'h1A00 + 16'(i), 16'hC300 + 16'(i * 17));
      if (i < 4) exp_q.push_back({16'h1A00 + 16'(i), 16'hC300 + 16'(i * 17)});
    end
    lr_edge(1'b1);
    chk("t3_count_full", {29'h0, fifo_count}, 32'h4);
    chk("t3_overflow", {31'h0, overflow}, 32'h1);
    chk("t3_head_left", {16'h0, left_channel_data}, 32'h1A00);
    pop_n(4);
    chk("t3_valid_drained", {31'h0, data_valid}, 32'h0);
    chk("t3_overflow_sticky", {31'h0, overflow}, 32'h1);

    // Short 12-bit slots are left-justified.
    pulse_clear();
    chk("t4_overflow_cleared", {31'h0, overflow}, 32'h0);
    send_slot(1'b1, 32'h0000_0ABC, 12, 0);
    send_slot(1'b0, 32'h0000_05A5, 12, 0);
    exp_q.push_back({16'hABC0, 16'h5A50});
    lr_edge(1'b1);
    chk("t4_count", {29'h0, fifo_count}, 32'h1);
    pop_n(1);

    // Full FIFO with a pop in the push cycle: push accepted, no overflow.
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      send_frame(16'h5000 + 16'(i * 3), 16'h0F00 + 16'(i));
      exp_q.push_back({16'h5000 + 16'(i * 3), 16'h0F00 + 16'(i)});
    end
    read_en = 1'b1;
    lr_edge(1'b1);
    read_en = 1'b0;
    chk("t5_count", {29'h0, fifo_count}, 32'h4);
    chk("t5_overflow", {31'h0, overflow}, 32'h0);
    pop_n(4);
    chk("t5_count_drained", {29'h0, fifo_count}, 32'h0);

    // MSB-edge word, then clear mid-frame flushes and forces a fresh sync.
    pulse_clear();
    send_frame(16'h8001, 16'h7FFE);
    lr_edge(1'b1);
    chk("t6_left", {16'h0, left_channel_data}, 32'h8001);
    chk("t6_right", {16'h0, right_channel_data}, 32'h7FFE);
    for (int k = 0; k < 5; k++) bit_pulse(k[0]);
    pulse_clear();
    chk("t6_count_cleared", {29'h0, fifo_count}, 32'h0);
    chk("t6_overflow_cleared", {31'h0, overflow}, 32'h0);
    chk("t6_valid_cleared", {31'h0, data_valid}, 32'h0);
    send_slot(1'b0, 32'h0000_BEEF, 16, PAD);
    send_slot(1'b1, 32'h0000_4444, 16, PAD);
    send_slot(1'b0, 32'h0000_5555, 16, PAD);
    chk("t6_no_push_on_sync", {29'h0, fifo_count}, 32'h0);
    exp_q.push_back({16'h4444, 16'h5555});
    lr_edge(1'b1);
    chk("t6_count", {29'h0, fifo_count}, 32'h1);
    pop_n(1);
    step();

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
